multiplier_slave: RTL and testbench

- Bus-slave register front end that sits directly upstream of the 64-bit Booth multiplier core.
- Accepts operand writes from the system bus.
- Generates the op_start and op_clear controls that drive the core's next-state logic.
- Captures the 128-bit product when the core raises op_done, exposes status and result for readback, and raises an interrupt.

---
 rtl/multiplier_slave_pkg.sv | 43 ++++
 rtl/multiplier_slave_if.sv | 28 ++
 rtl/multiplier_slave_dec.sv | 39 +++
 rtl/multiplier_slave.sv | 99 +++++++++
 tb/tb_multiplier_slave.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/multiplier_slave_pkg.sv
// Shared constants for the multiplier bus slave: register offsets, FSM encoding,
// read-mux selects and the decoder strobe bundle.
package multiplier_pkg;

  localparam int DATA_W_DEF = 64;

  // Word offsets inside the low 8-word window; anything at 0x8 and above is reserved.
  localparam logic [2:0] ADDR_MULTIPLICAND = 3'h0;
  localparam logic [2:0] ADDR_MULTIPLIER   = 3'h1;
  localparam logic [2:0] ADDR_OPSTART      = 3'h2;
  localparam logic [2:0] ADDR_OPCLEAR      = 3'h3;
  localparam logic [2:0] ADDR_OPDONE       = 3'h4;
  localparam logic [2:0] ADDR_INTR_EN      = 3'h5;
  localparam logic [2:0] ADDR_RESULT_H     = 3'h6;
  localparam logic [2:0] ADDR_RESULT_L     = 3'h7;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } slv_state_e;

  typedef enum logic [2:0] {
    RD_ZERO,
    RD_MCAND,
    RD_MPLIER,
    RD_START,
    RD_STATUS,
    RD_INTEN,
    RD_RESH,
    RD_RESL
  } rd_sel_e;

  typedef struct packed {
    logic mcand;
    logic mplier;
    logic start;
    logic clear;
    logic inten;
    logic rd;
  } dec_t;

endpackage

// File: rtl/multiplier_slave_if.sv
// Bus + core-side signal bundle of the multiplier slave.
interface multiplier_slave_if #(
  parameter int DATA_W = multiplier_pkg::DATA_W_DEF,
  parameter int ADDR_W = 4
);
  logic                  s_sel;
  logic                  s_wr;
  logic [ADDR_W-1:0]     s_addr;
  logic [DATA_W-1:0]     s_din;
  logic [DATA_W-1:0]     s_dout;
  logic                  m_interrupt;
  logic [DATA_W-1:0]     multiplicand;
  logic [DATA_W-1:0]     multiplier;
  logic                  op_start;
  logic                  op_clear;
  logic                  op_done;
  logic [2*DATA_W-1:0]   result;

  modport slave (
    input  s_sel, s_wr, s_addr, s_din, op_done, result,
    output s_dout, m_interrupt, multiplicand, multiplier, op_start, op_clear
  );

  modport master (
    output s_sel, s_wr, s_addr, s_din, op_done, result,
    input  s_dout, m_interrupt, multiplicand, multiplier, op_start, op_clear
  );
endinterface

// File: rtl/multiplier_slave_dec.sv
// Address decoder: per-register write strobes and the read-mux select.
module multiplier_slave_dec
  import multiplier_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              i_sel,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  output dec_t              o_we,
  output rd_sel_e           o_rd_sel
);

  logic       w_hit;
  logic [2:0] w_off;

  assign w_off = i_addr[2:0];
  assign w_hit = (i_addr >> 3) == '0;

  always_comb begin
    o_we     = '0;
    o_rd_sel = RD_ZERO;
    o_we.rd  = i_sel & ~i_wr;
    if (i_sel && w_hit) begin
      case (w_off)
        ADDR_MULTIPLICAND: begin o_we.mcand  = i_wr; o_rd_sel = RD_MCAND;  end
        ADDR_MULTIPLIER:   begin o_we.mplier = i_wr; o_rd_sel = RD_MPLIER; end
        ADDR_OPSTART:      begin o_we.start  = i_wr; o_rd_sel = RD_START;  end
        ADDR_OPCLEAR:      o_we.clear = i_wr;
        ADDR_OPDONE:       o_rd_sel = RD_STATUS;
        ADDR_INTR_EN:      begin o_we.inten  = i_wr; o_rd_sel = RD_INTEN;  end
        ADDR_RESULT_H:     o_rd_sel = RD_RESH;
        ADDR_RESULT_L:     o_rd_sel = RD_RESL;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multiplier_slave.sv
// Register front end for the Booth multiplier core: operand/control registers,
// IDLE/BUSY/DONE sequencing, product capture, status readback and interrupt.
module multiplier_slave
  import multiplier_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  multiplier_slave_if.slave   bus
);

  slv_state_e          r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_mcand, r_mplier, r_res_h, r_res_l, r_dout;
  logic [DATA_W-1:0]   w_rdata;
  logic                r_inten, r_op_clear;
  dec_t                w_we;
  rd_sel_e             w_rd_sel;
  logic                w_clr, w_start, w_capture, w_busy, w_done_flag, w_op_start;

  multiplier_slave_dec #(.ADDR_W(ADDR_W)) u_dec (
    .i_sel    (bus.s_sel),
    .i_wr     (bus.s_wr),
    .i_addr   (bus.s_addr),
    .o_we     (w_we),
    .o_rd_sel (w_rd_sel)
  );

  assign w_clr       = w_we.clear & bus.s_din[0];
  assign w_start     = w_we.start & bus.s_din[0];
  assign w_busy      = (r_state == S_BUSY);
  assign w_done_flag = (r_state == S_DONE);
  assign w_op_start  = (r_state != S_IDLE);
  // Clear beats a completion landing on the same edge: nothing is captured.
  assign w_capture   = w_busy & bus.op_done & ~w_clr;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
      S_BUSY:  if (bus.op_done) w_state_nxt = S_DONE;
      S_DONE:  ;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_clr) w_state_nxt = S_IDLE;
  end

  always_comb begin
    w_rdata = '0;
    case (w_rd_sel)
      RD_MCAND:  w_rdata = r_mcand;
      RD_MPLIER: w_rdata = r_mplier;
      RD_START:  w_rdata[0] = w_op_start;
      RD_STATUS: w_rdata[1:0] = {w_done_flag, w_busy};
      RD_INTEN:  w_rdata[0] = r_inten;
      RD_RESH:   w_rdata = r_res_h;
      RD_RESL:   w_rdata = r_res_l;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_inten    <= 1'b0;
      r_res_h    <= '0;
      r_res_l    <= '0;
      r_dout     <= '0;
      r_op_clear <= 1'b0;
    end else begin
      r_op_clear <= w_clr;
      // Operands are frozen while the core is iterating.
      if (w_we.mcand  && !w_busy) r_mcand  <= bus.s_din;
      if (w_we.mplier && !w_busy) r_mplier <= bus.s_din;
      if (w_we.inten)             r_inten  <= bus.s_din[0];
      if (w_clr) begin
        r_res_h <= '0;
        r_res_l <= '0;
      end else if (w_capture) begin
        {r_res_h, r_res_l} <= bus.result;
      end
      if (w_we.rd) r_dout <= w_rdata;
    end
  end

  assign bus.s_dout       = r_dout;
  assign bus.m_interrupt  = w_done_flag & r_inten;
  assign bus.multiplicand = r_mcand;
  assign bus.multiplier   = r_mplier;
  assign bus.op_start     = w_op_start;
  assign bus.op_clear     = r_op_clear;

endmodule

// File: tb/tb_multiplier_slave.sv
// Bench for multiplier_slave: directed register-map scenarios plus random bus
// traffic, every cycle compared against a behavioural model of the register map.
module tb_multiplier_slave;
  localparam int DW = 64;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multiplier_slave_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
  multiplier_slave #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model; m_phase: 0 = nothing running, 1 = core working, 2 = product held.
  logic [63:0] m_a, m_b, m_rh, m_rl, m_dout;
  bit          m_inten, m_clr;
  int          m_phase;

  logic         core_done;
  logic [127:0] core_res;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_rh = '0; m_rl = '0; m_dout = '0;
    m_inten = 1'b0; m_clr = 1'b0; m_phase = 0;
  endtask

  task automatic model_edge(input logic sel, input logic wr, input logic [3:0] a,
                            input logic [63:0] d, input logic done, input logic [127:0] res);
    logic [63:0] rd;
    int ph0;
    ph0 = m_phase;
    case (a)
      4'h0:    rd = m_a;
      4'h1:    rd = m_b;
      4'h2:    rd = {63'b0, ph0 != 0};
      4'h4:    rd = {62'b0, ph0 == 2, ph0 == 1};
      4'h5:    rd = {63'b0, m_inten};
      4'h6:    rd = m_rh;
      4'h7:    rd = m_rl;
      default: rd = '0;
    endcase
    if (sel && !wr) m_dout = rd;
    m_clr = sel && wr && (a == 4'h3) && d[0];
    if (m_clr) begin
      m_phase = 0; m_rh = '0; m_rl = '0;
    end else begin
      if (sel && wr) begin
        if (a == 4'h0 && ph0 != 1) m_a = d;
        if (a == 4'h1 && ph0 != 1) m_b = d;
        if (a == 4'h2 && d[0] && ph0 == 0) m_phase = 1;
        if (a == 4'h5) m_inten = d[0];
      end
      if (ph0 == 1 && done) begin
        m_phase = 2;
        {m_rh, m_rl} = res;
      end
    end
  endtask

  task automatic check_outs();
    chk("s_dout",       bus.s_dout,       m_dout);
    chk("m_interrupt",  bus.m_interrupt,  (m_phase == 2) && m_inten);
    chk("multiplicand", bus.multiplicand, m_a);
    chk("multiplier",   bus.multiplier,   m_b);
    chk("op_start",     bus.op_start,     m_phase != 0);
    chk("op_clear",     bus.op_clear,     m_clr);
  endtask

  task automatic cyc(input logic sel, input logic wr, input logic [3:0] a, input logic [63:0] d);
    bus.s_sel = sel; bus.s_wr = wr; bus.s_addr = a; bus.s_din = d;
    bus.op_done = core_done; bus.result = core_res;
    @(posedge clk);
    model_edge(sel, wr, a, d, core_done, core_res);
    #1;
    check_outs();
  endtask

  task automatic wr(input logic [3:0] a, input logic [63:0] d);
    cyc(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [3:0] a, input logic [63:0] exp, input string tag);
    cyc(1'b1, 1'b0, a, 64'd0);
    chk(tag, bus.s_dout, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    core_done = 1'b0; core_res = '0;
    bus.s_sel = 1'b0; bus.s_wr = 1'b0; bus.s_addr = '0; bus.s_din = '0;
    bus.op_done = 1'b0; bus.result = '0;
    model_reset();
    #12;
    chk("rst_dout",  bus.s_dout, 0);
    chk("rst_start", bus.op_start, 0);
    chk("rst_clear", bus.op_clear, 0);
    chk("rst_irq",   bus.m_interrupt, 0);
    #5 rst_n = 1'b1;
    rd(4'h4, 64'h0, "rst_opdone");

    // Normal run: 7 * -3
    wr(4'h0, 64'h0000_0000_0000_0007);
    wr(4'h1, 64'hFFFF_FFFF_FFFF_FFFD);
    wr(4'h5, 64'h1);
    wr(4'h2, 64'h1);
    chk("run_op_start", bus.op_start, 1);
    rd(4'h4, 64'h1, "busy_status");
    wr(4'h0, 64'h1234);
    chk("lock_mcand", bus.multiplicand, 64'h7);
    rd(4'h0, 64'h7, "lock_readback");
    idle(60);
    core_done = 1'b1;
    core_res  = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB;
    rd(4'h4, 64'h1, "status_pre_edge");
    chk("irq_after_done", bus.m_interrupt, 1);
    rd(4'h4, 64'h2, "done_status");
    rd(4'h6, 64'hFFFF_FFFF_FFFF_FFFF, "result_h");
    rd(4'h7, 64'hFFFF_FFFF_FFFF_FFEB, "result_l");

    wr(4'h2, 64'h1);
    rd(4'h4, 64'h2, "restart_ignored");
    wr(4'h0, 64'h1234);
    chk("done_mcand_accept", bus.multiplicand, 64'h1234);
    wr(4'h5, 64'h0);
    chk("irq_en_off", bus.m_interrupt, 0);
    wr(4'h5, 64'h1);
    chk("irq_en_on", bus.m_interrupt, 1);

    // Clear from DONE
    wr(4'h3, 64'h1);
    chk("clr_pulse", bus.op_clear, 1);
    chk("clr_start", bus.op_start, 0);
    chk("clr_irq",   bus.m_interrupt, 0);
    core_done = 1'b0;
    idle(1);
    chk("clr_one_cycle", bus.op_clear, 0);
    rd(4'h7, 64'h0, "clr_result_l");
    rd(4'h4, 64'h0, "clr_status");
    rd(4'h0, 64'h1234, "mcand_rb");
    rd(4'hA, 64'h0, "reserved_rd");

    // Clear racing the core's completion
    wr(4'h2, 64'h1);
    idle(3);
    core_done = 1'b1; core_res = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    wr(4'h3, 64'h1);
    core_done = 1'b0;
    chk("race_start", bus.op_start, 0);
    chk("race_irq", bus.m_interrupt, 0);
    rd(4'h7, 64'h0, "race_result_l");
    rd(4'h4, 64'h0, "race_status");

    // Completion while idle is ignored
    core_done = 1'b1;
    idle(2);
    core_done = 1'b0;
    rd(4'h6, 64'h0, "idle_done_ignored");

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [3:0]  a;
      logic [63:0] d;
      a = ($urandom % 5 == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      d = {$urandom, $urandom};
      if (a == 4'h3 && ($urandom % 3 != 0)) d[0] = 1'b0;
      core_done = ($urandom % 6 == 0);
      core_res  = {$urandom, $urandom, $urandom, $urandom};
      cyc($urandom % 4 != 0, $urandom % 2 == 1, a, d);
    end
    core_done = 1'b0;

    // Mid-stream async reset during a run
    wr(4'h0, 64'h5);
    wr(4'h3, 64'h1);
    wr(4'h5, 64'h1);
    wr(4'h2, 64'h1);
    core_done = 1'b1; core_res = 128'h9;
    idle(2);
    core_done = 1'b0;
    chk("pre_rst_irq", bus.m_interrupt, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_start", bus.op_start, 0);
    chk("async_irq",   bus.m_interrupt, 0);
    chk("async_mcand", bus.multiplicand, 0);
    chk("async_dout",  bus.s_dout, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    rd(4'h4, 64'h0, "post_rst_status");
    rd(4'h6, 64'h0, "post_rst_result_h");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
